// File: rtl/noc_local_injector_pkg.sv
// Shared NoC definitions: node/VC sizing, flit layout and injector state encoding.
package Noc_parameters;

  localparam int Noc_VC_Channel      = 4;
  localparam int Noc_ID_X_Width      = 4;
  localparam int Noc_ID_Y_Width      = 4;
  localparam int Noc_Flit_Body_Width = 32;

  // Head flit layout, LSB first: len (8 bits reserved), src_y, src_x, dst_y, dst_x.
  localparam int Noc_Head_Len_Width  = 8;
  localparam int Noc_Head_Len_Ofs    = 0;
  localparam int Noc_Head_Src_Y_Ofs  = Noc_Head_Len_Ofs + Noc_Head_Len_Width;
  localparam int Noc_Head_Src_X_Ofs  = Noc_Head_Src_Y_Ofs + Noc_ID_Y_Width;
  localparam int Noc_Head_Dst_Y_Ofs  = Noc_Head_Src_X_Ofs + Noc_ID_X_Width;
  localparam int Noc_Head_Dst_X_Ofs  = Noc_Head_Dst_Y_Ofs + Noc_ID_Y_Width;

  typedef enum logic [1:0] {
    FT_HEAD   = 2'd0,
    FT_BODY   = 2'd1,
    FT_TAIL   = 2'd2,
    FT_SINGLE = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e                     ftype;
    logic [Noc_Flit_Body_Width-1:0] body;
  } Noc_flit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VCSEL = 2'd1,
    HEAD  = 2'd2,
    BODY  = 2'd3
  } injector_state_e;

endpackage

// File: rtl/noc_local_injector_vc_select.sv
// Combinational lowest-index picker over the per-VC ready vector.
module noc_vc_select #(
  parameter int CHANNELS = 4,
  parameter int VC_W     = 2
) (
  input  logic [CHANNELS-1:0] vc_ready,
  output logic [CHANNELS-1:0] grant,
  output logic [VC_W-1:0]     grant_idx,
  output logic                any_ready
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (vc_ready[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = i[VC_W-1:0];
      end
    end
  end

  assign any_ready = |vc_ready;

endmodule

// File: rtl/noc_local_injector.sv
// Packetizes core descriptors and payload words into head/body/tail flits
// and drives them on one free virtual channel of a router local port.
module noc_local_injector
  import Noc_parameters::*;
#(
  parameter int CHANNELS  = Noc_VC_Channel,
  parameter int PAYLOAD_W = 32,
  parameter int LEN_W     = 4
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [Noc_ID_X_Width-1:0] id_x,
  input  logic [Noc_ID_Y_Width-1:0] id_y,
  input  logic                      pkt_valid,
  output logic                      pkt_ready,
  input  logic [Noc_ID_X_Width-1:0] pkt_dst_x,
  input  logic [Noc_ID_Y_Width-1:0] pkt_dst_y,
  input  logic [LEN_W-1:0]          pkt_len,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic [PAYLOAD_W-1:0]      data,
  output logic [CHANNELS-1:0]       flit_valid,
  output Noc_flit_t                 flit,
  input  logic [CHANNELS-1:0]       flit_ready,
  input  logic [CHANNELS-1:0]       vc_ready,
  output logic                      busy,
  output logic [15:0]               pkt_count
);

  localparam int VC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  injector_state_e           state;
  logic [Noc_ID_X_Width-1:0] dst_x_q;
  logic [Noc_ID_Y_Width-1:0] dst_y_q;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          remain;
  logic [VC_W-1:0]           vc;
  logic [CHANNELS-1:0]       vc_onehot;
  logic                      out_full;
  logic                      pkt_ready_q;

  logic [CHANNELS-1:0]       sel_grant;
  logic [VC_W-1:0]           sel_idx;
  logic                      sel_any;
  logic                      flit_xfer;
  logic                      data_xfer;
  Noc_flit_t                 head_flit;
  Noc_flit_t                 data_flit;

  noc_vc_select #(
    .CHANNELS (CHANNELS),
    .VC_W     (VC_W)
  ) u_vc_select (
    .vc_ready  (vc_ready),
    .grant     (sel_grant),
    .grant_idx (sel_idx),
    .any_ready (sel_any)
  );

  assign pkt_ready  = pkt_ready_q;
  assign busy       = (state != IDLE);
  assign flit_valid = out_full ? vc_onehot : '0;
  assign flit_xfer  = out_full & flit_ready[vc];
  // Once the tail word is loaded (remain hits 0) no further words are taken.
  assign data_ready = (state == BODY) && (remain != '0) && (!out_full || flit_ready[vc]);
  assign data_xfer  = data_valid & data_ready;

  always_comb begin
    head_flit.ftype = (len_q == '0) ? FT_SINGLE : FT_HEAD;
    head_flit.body  = '0;
    head_flit.body[Noc_Head_Dst_X_Ofs +: Noc_ID_X_Width] = dst_x_q;
    head_flit.body[Noc_Head_Dst_Y_Ofs +: Noc_ID_Y_Width] = dst_y_q;
    head_flit.body[Noc_Head_Src_X_Ofs +: Noc_ID_X_Width] = id_x;
    head_flit.body[Noc_Head_Src_Y_Ofs +: Noc_ID_Y_Width] = id_y;
    head_flit.body[Noc_Head_Len_Ofs +: LEN_W]            = len_q;

    data_flit.ftype = (remain == LEN_ONE) ? FT_TAIL : FT_BODY;
    data_flit.body  = '0;
    data_flit.body[PAYLOAD_W-1:0] = data;
  end

  // The output register holds a flit until its transfer; out_full is its valid.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state       <= IDLE;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      len_q       <= '0;
      remain      <= '0;
      vc          <= '0;
      vc_onehot   <= '0;
      out_full    <= 1'b0;
      pkt_ready_q <= 1'b0;
      flit        <= '0;
      pkt_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          pkt_ready_q <= 1'b1;
          if (pkt_valid && pkt_ready_q) begin
            dst_x_q     <= pkt_dst_x;
            dst_y_q     <= pkt_dst_y;
            len_q       <= pkt_len;
            remain      <= pkt_len;
            pkt_ready_q <= 1'b0;
            state       <= VCSEL;
          end
        end
        VCSEL: begin
          if (sel_any) begin
            vc        <= sel_idx;
            vc_onehot <= sel_grant;
            flit      <= head_flit;
            out_full  <= 1'b1;
            state     <= HEAD;
          end
        end
        HEAD: begin
          if (flit_xfer) begin
            out_full <= 1'b0;
            if (len_q == '0) begin
              pkt_count   <= pkt_count + 16'd1;
              pkt_ready_q <= 1'b1;
              state       <= IDLE;
            end else begin
              state <= BODY;
            end
          end
        end
        BODY: begin
          if (data_xfer) begin
            flit     <= data_flit;
            out_full <= 1'b1;
            remain   <= remain - LEN_ONE;
          end else if (flit_xfer) begin
            out_full <= 1'b0;
          end
          if (flit_xfer && (flit.ftype == FT_TAIL)) begin
            pkt_count   <= pkt_count + 16'd1;
            pkt_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
